// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge: every accepted AHB transfer becomes one
// non-pipelined APB transfer, with AHB wait states inserted through HREADYOUT.
module ahb3lite_apb_bridge #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [3:0]            HPROT,
    input  logic [2:0]            HBURST,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [HDATA_SIZE-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    input  logic [HDATA_SIZE-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LATCH, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [PADDR_SIZE-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [HDATA_SIZE-1:0] hrdata_q, hrdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [HDATA_SIZE-1:0] pwdata_q, pwdata_d;
    logic [3:0]            pstrb_q, pstrb_d;

    logic       accept;
    logic       size_err;
    logic [3:0] strb;
    logic       unused_ok;

    assign accept   = HSEL & HREADY & HTRANS[1] & ((state_q == ST_IDLE) | (state_q == ST_ERR2));
    assign size_err = (HSIZE > 3'd2);
    assign unused_ok = ^{HPROT, HBURST, HMASTLOCK, HTRANS[0], HADDR[HADDR_SIZE-1:PADDR_SIZE]};

    always_comb begin
        strb = 4'b0000;
        if (write_q) begin
            case (size_q)
                2'd0:    strb = 4'b0001 << addr_q[1:0];
                2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
                default: strb = 4'b1111;
            endcase
        end
    end

    // NOTE: reset is asynchronous, so a transfer in flight is dropped at once, not at the next edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) state_d = size_err ? ST_ERR1 : ST_LATCH;
                else        state_d = ST_IDLE;
            end
            ST_LATCH:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY) state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every _d starts as its _q so each path holds by default and no latch is inferred.
    always_comb begin
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (accept) begin
                    addr_d      = HADDR[PADDR_SIZE-1:0];
                    write_d     = HWRITE;
                    size_d      = HSIZE[1:0];
                    hreadyout_d = 1'b0;
                    hresp_d     = size_err;
                end
            end
            ST_LATCH: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = addr_q;
                pwrite_d  = write_q;
                pwdata_d  = HWDATA;
                pstrb_d   = strb;
            end
            ST_SETUP: penable_d = 1'b1;
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        hresp_d = 1'b1;
                    end else begin
                        hreadyout_d = 1'b1;
                        if (!write_q) hrdata_d = PRDATA;
                    end
                end
            end
            ST_ERR1: begin
                hresp_d     = 1'b1;
                hreadyout_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed bench for ahb3lite_apb_bridge: an AHB master driven from tasks and a
// small APB slave whose PREADY delay and PSLVERR are set per scenario.
module tb_ahb3lite_apb_bridge;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    int pready_wait = 0;
    int acc_cnt     = 0;
    int psel_cycles = 0;
    logic [15:0] mon_addr[$];
    logic        mon_write[$];
    logic [31:0] mon_wdata[$];
    logic [3:0]  mon_strb[$];

    ahb3lite_apb_bridge #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .PADDR_SIZE(16)
    ) dut (
        .HCLK      (hclk),
        .HRESETn   (hresetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HWDATA    (hwdata),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HTRANS    (htrans),
        .HPROT     (hprot),
        .HBURST    (hburst),
        .HMASTLOCK (hmastlock),
        .HREADY    (hready),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .HRDATA    (hrdata),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PADDR     (paddr),
        .PWRITE    (pwrite),
        .PWDATA    (pwdata),
        .PSTRB     (pstrb),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // APB slave: PREADY stays low for pready_wait ACCESS cycles, then rises.
    assign pready = (acc_cnt >= pready_wait);
    always @(posedge hclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel) psel_cycles <= psel_cycles + 1;
        if (psel && penable && pready) begin
            mon_addr.push_back(paddr);
            mon_write.push_back(pwrite);
            mon_wdata.push_back(pwdata);
            mon_strb.push_back(pstrb);
        end
    end

    // Presents one address phase at the current negedge, then counts wait cycles
    // until HREADYOUT rises again; returns positioned on the completion cycle.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [1:0] trans, input logic [31:0] wdata, output int waits);
        hsel   = 1'b1;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = trans;
        @(negedge hclk);
        htrans = TR_IDLE;
        hwdata = wdata;
        waits  = 0;
        while (hreadyout !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge hclk);
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout got=%b exp=1", hreadyout); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
        n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        n_checks++; if ({psel, penable, pwrite} !== 3'b000) begin n_fail++; $display("FAIL reset_apb_ctrl got=%b exp=000", {psel, penable, pwrite}); end
        n_checks++; if (paddr !== 16'h0) begin n_fail++; $display("FAIL reset_paddr got=%h exp=0", paddr); end
        n_checks++; if (pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata got=%h exp=0", pwdata); end
        n_checks++; if (pstrb !== 4'h0) begin n_fail++; $display("FAIL reset_pstrb got=%h exp=0", pstrb); end
        hresetn = 1'b1;
        @(negedge hclk);
    endtask

    task automatic test_single_write();
        int waits;
        int base = mon_addr.size();
        do_xfer(32'h0000_1234, 1'b1, 3'd2, TR_NONSEQ, 32'hDEAD_BEEF, waits);
        n_checks++; if (waits !== 3) begin n_fail++; $display("FAIL wr_wait_cycles got=%0d exp=3", waits); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL wr_hresp got=%b exp=0", hresp); end
        n_checks++; if (mon_addr.size() - base !== 1) begin n_fail++; $display("FAIL wr_apb_count got=%0d exp=1", mon_addr.size() - base); end
        else begin
            n_checks++; if (mon_addr[base] !== 16'h1234) begin n_fail++; $display("FAIL wr_paddr got=%h exp=1234", mon_addr[base]); end
            n_checks++; if (mon_write[base] !== 1'b1) begin n_fail++; $display("FAIL wr_pwrite got=%b exp=1", mon_write[base]); end
            n_checks++; if (mon_wdata[base] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_pwdata got=%h exp=deadbeef", mon_wdata[base]); end
            n_checks++; if (mon_strb[base] !== 4'hF) begin n_fail++; $display("FAIL wr_pstrb got=%h exp=f", mon_strb[base]); end
        end
    endtask

    task automatic test_byte_read();
        int waits;
        int base = mon_addr.size();
        pready_wait = 2;
        prdata      = 32'h1122_3344;
        do_xfer(32'h0000_0013, 1'b0, 3'd0, TR_NONSEQ, 32'h0, waits);
        pready_wait = 0;
        n_checks++; if (waits !== 5) begin n_fail++; $display("FAIL rd_wait_cycles got=%0d exp=5", waits); end
        n_checks++; if (hrdata !== 32'h1122_3344) begin n_fail++; $display("FAIL rd_hrdata got=%h exp=11223344", hrdata); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL rd_hresp got=%b exp=0", hresp); end
        n_checks++; if (mon_addr.size() - base !== 1) begin n_fail++; $display("FAIL rd_apb_count got=%0d exp=1", mon_addr.size() - base); end
        else begin
            n_checks++; if (mon_addr[base] !== 16'h0013) begin n_fail++; $display("FAIL rd_paddr got=%h exp=0013", mon_addr[base]); end
            n_checks++; if (mon_write[base] !== 1'b0) begin n_fail++; $display("FAIL rd_pwrite got=%b exp=0", mon_write[base]); end
            n_checks++; if (mon_strb[base] !== 4'h0) begin n_fail++; $display("FAIL rd_pstrb got=%h exp=0", mon_strb[base]); end
        end
    endtask

    task automatic test_halfword_error();
        pslverr = 1'b1;
        hsel    = 1'b1;
        haddr   = 32'h0000_0002;
        hwrite  = 1'b1;
        hsize   = 3'd1;
        htrans  = TR_NONSEQ;
        @(negedge hclk);
        htrans = TR_IDLE;
        hwdata = 32'hCAFE_0000;
        repeat (2) @(negedge hclk);
        n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL err_access_phase got=%b exp=11", {psel, penable}); end
        n_checks++; if (pstrb !== 4'b1100) begin n_fail++; $display("FAIL err_pstrb got=%b exp=1100", pstrb); end
        n_checks++; if (paddr !== 16'h0002) begin n_fail++; $display("FAIL err_paddr got=%h exp=0002", paddr); end
        n_checks++; if (pwdata !== 32'hCAFE_0000) begin n_fail++; $display("FAIL err_pwdata got=%h exp=cafe0000", pwdata); end
        @(negedge hclk);
        n_checks++; if ({hresp, hreadyout, psel} !== 3'b100) begin n_fail++; $display("FAIL err_cycle1 hresp/hreadyout/psel got=%b exp=100", {hresp, hreadyout, psel}); end
        @(negedge hclk);
        pslverr = 1'b0;
        n_checks++; if ({hresp, hreadyout} !== 2'b11) begin n_fail++; $display("FAIL err_cycle2 hresp/hreadyout got=%b exp=11", {hresp, hreadyout}); end
        @(negedge hclk);
        n_checks++; if ({hresp, hreadyout} !== 2'b01) begin n_fail++; $display("FAIL err_after hresp/hreadyout got=%b exp=01", {hresp, hreadyout}); end
    endtask

    task automatic test_burst();
        int waits;
        int base  = mon_addr.size();
        int psel0 = psel_cycles;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                haddr  = 32'h0000_0108;
                htrans = TR_BUSY;
                @(negedge hclk);
                n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++; $display("FAIL burst_busy_okay hreadyout/hresp got=%b exp=10", {hreadyout, hresp}); end
            end
            do_xfer(32'h0000_0100 + 32'(4 * i), 1'b1, 3'd2, (i == 0) ? TR_NONSEQ : TR_SEQ,
                    32'hB000_0000 + 32'(i), waits);
            n_checks++; if (waits !== 3) begin n_fail++; $display("FAIL burst_beat%0d_waits got=%0d exp=3", i, waits); end
        end
        n_checks++; if (psel_cycles - psel0 !== 8) begin n_fail++; $display("FAIL burst_psel_cycles got=%0d exp=8", psel_cycles - psel0); end
        n_checks++; if (mon_addr.size() - base !== 4) begin n_fail++; $display("FAIL burst_apb_count got=%0d exp=4", mon_addr.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (mon_addr[base + i] !== 16'(32'h100 + 4 * i)) begin n_fail++; $display("FAIL burst_paddr%0d got=%h exp=%h", i, mon_addr[base + i], 16'(32'h100 + 4 * i)); end
                n_checks++; if (mon_wdata[base + i] !== 32'hB000_0000 + 32'(i)) begin n_fail++; $display("FAIL burst_pwdata%0d got=%h exp=%h", i, mon_wdata[base + i], 32'hB000_0000 + 32'(i)); end
            end
        end
    endtask

    task automatic test_size_error();
        int waits;
        int psel0 = psel_cycles;
        prdata = 32'h5A5A_A5A5;
        hsel   = 1'b1;
        haddr  = 32'h0000_0040;
        hwrite = 1'b0;
        hsize  = 3'd3;
        htrans = TR_NONSEQ;
        @(negedge hclk);
        htrans = TR_IDLE;
        n_checks++; if ({hresp, hreadyout, psel} !== 3'b100) begin n_fail++; $display("FAIL size_err_cycle1 hresp/hreadyout/psel got=%b exp=100", {hresp, hreadyout, psel}); end
        @(negedge hclk);
        n_checks++; if ({hresp, hreadyout} !== 2'b11) begin n_fail++; $display("FAIL size_err_cycle2 hresp/hreadyout got=%b exp=11", {hresp, hreadyout}); end
        // Next transfer presented during the second error cycle must be accepted.
        do_xfer(32'h0000_0044, 1'b0, 3'd2, TR_NONSEQ, 32'h0, waits);
        n_checks++; if (waits !== 3) begin n_fail++; $display("FAIL err2_accept_waits got=%0d exp=3", waits); end
        n_checks++; if (hrdata !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL err2_accept_hrdata got=%h exp=5a5aa5a5", hrdata); end
        n_checks++; if (psel_cycles - psel0 !== 2) begin n_fail++; $display("FAIL size_err_psel_cycles got=%0d exp=2", psel_cycles - psel0); end
    endtask

    task automatic test_unselected();
        int psel0 = psel_cycles;
        hsel   = 1'b0;
        haddr  = 32'h0000_0200;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = TR_NONSEQ;
        @(negedge hclk);
        n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++; $display("FAIL hsel_low hreadyout/hresp got=%b exp=10", {hreadyout, hresp}); end
        hsel   = 1'b1;
        hready = 1'b0;
        @(negedge hclk);
        n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++; $display("FAIL hready_low hreadyout/hresp got=%b exp=10", {hreadyout, hresp}); end
        hready = 1'b1;
        htrans = TR_IDLE;
        @(negedge hclk);
        n_checks++; if (psel_cycles - psel0 !== 0) begin n_fail++; $display("FAIL unselected_psel_cycles got=%0d exp=0", psel_cycles - psel0); end
    endtask

    task automatic test_reset_mid_access();
        int waits;
        int base;
        pready_wait = 10;
        hsel   = 1'b1;
        haddr  = 32'h0000_0080;
        hwrite = 1'b0;
        hsize  = 3'd2;
        htrans = TR_NONSEQ;
        @(negedge hclk);
        htrans = TR_IDLE;
        repeat (2) @(negedge hclk);
        n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL midrst_access_phase got=%b exp=11", {psel, penable}); end
        #2 hresetn = 1'b0;
        #1;
        n_checks++; if ({psel, penable, hresp, hreadyout} !== 4'b0001) begin n_fail++; $display("FAIL midrst_outputs psel/penable/hresp/hreadyout got=%b exp=0001", {psel, penable, hresp, hreadyout}); end
        n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL midrst_hrdata got=%h exp=0", hrdata); end
        @(negedge hclk);
        hresetn     = 1'b1;
        pready_wait = 0;
        @(negedge hclk);
        base = mon_addr.size();
        do_xfer(32'h0000_0044, 1'b1, 3'd2, TR_NONSEQ, 32'h0102_0304, waits);
        n_checks++; if (waits !== 3) begin n_fail++; $display("FAIL postrst_waits got=%0d exp=3", waits); end
        n_checks++; if (mon_addr.size() - base !== 1) begin n_fail++; $display("FAIL postrst_apb_count got=%0d exp=1", mon_addr.size() - base); end
        else begin
            n_checks++; if (mon_wdata[base] !== 32'h0102_0304) begin n_fail++; $display("FAIL postrst_pwdata got=%h exp=01020304", mon_wdata[base]); end
        end
    endtask

    initial begin
        hresetn   = 1'b0;
        hsel      = 1'b0;
        haddr     = 32'h0;
        hwdata    = 32'h0;
        hwrite    = 1'b0;
        hsize     = 3'd0;
        htrans    = TR_IDLE;
        hprot     = 4'b0011;
        hburst    = 3'b000;
        hmastlock = 1'b0;
        hready    = 1'b1;
        prdata    = 32'h0;
        pslverr   = 1'b0;

        test_reset();
        test_single_write();
        test_byte_read();
        test_halfword_error();
        test_burst();
        test_size_error();
        test_unselected();
        test_reset_mid_access();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb3lite_apb_bridge.md
Name: ahb3lite_apb_bridge

Overview:
AHB3-Lite slave that converts each accepted AHB transfer into a single APB4 transfer. It consumes the transfers driven by the ahb_if master driver and sits between the AHB interconnect and one APB peripheral on the same clock. Each transfer is handled non-pipelined on the APB side; AHB wait states are inserted with HREADYOUT.

Parameters:
HADDR_SIZE, 32, AHB address width (matches ahb3lite_pkg)
HDATA_SIZE, 32, AHB and APB data width; only 32 is supported
PADDR_SIZE, 16, APB address width; PADDR = HADDR[PADDR_SIZE-1:0]

Ports:
HCLK  in  1  clock, shared by the AHB and APB sides
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  address-phase address
HWDATA  in  HDATA_SIZE  write data, valid in the data phase
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HPROT, HBURST, HMASTLOCK  in  4/3/1  accepted and ignored
HREADY  in  1  bus-level ready; address phase sampled only when 1
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  HDATA_SIZE  read data
PSEL  out  1  APB select
PENABLE  out  1  APB access phase
PADDR  out  PADDR_SIZE  APB address
PWRITE  out  1  APB direction
PWDATA  out  HDATA_SIZE  APB write data
PSTRB  out  4  byte strobes for writes, 0 for reads
PRDATA  in  HDATA_SIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error, sampled with PREADY

Behaviour:
- All outputs are registered. The reset is asynchronous. While HRESETn=0: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, state=IDLE. A reset in the middle of a transfer aborts it immediately.
- Accept condition: HSEL & HREADY & HTRANS[1] sampled at a rising edge while state is IDLE or ERR2. On accept, latch HADDR, HWRITE and HSIZE.
- IDLE or BUSY with HSEL=1: zero-wait OKAY response, no APB activity.
- Size check: HSIZE>2 on an accepted transfer goes to ERR1 with no APB access.
- Strobes for writes: HSIZE=0 gives 1<<HADDR[1:0]; HSIZE=1 gives 4'b0011<<(2*HADDR[1]); HSIZE=2 gives 4'b1111. Misaligned addresses are not checked; the low bits pass through to PADDR.
- FSM states: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: HREADYOUT=1. On accept, go to LATCH and set HREADYOUT=0.
  - LATCH: AHB data-phase cycle. Capture HWDATA into PWDATA. Drive PSEL=1, PENABLE=0, PADDR, PWRITE, PSTRB. Go to SETUP.
  - SETUP: go to ACCESS and set PENABLE=1.
  - ACCESS: hold until PREADY=1. Then drop PSEL and PENABLE.
    - PSLVERR=0: HRDATA<=PRDATA for reads (HRDATA is held for writes), HREADYOUT<=1, go to IDLE.
    - PSLVERR=1: go to ERR1.
  - ERR1: HRESP=1, HREADYOUT=0. Go to ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Go to IDLE. A transfer presented in this cycle that meets the accept condition is accepted (LATCH next). An IDLE cancel from the master is honoured.
- Latency with PREADY tied high: accept edge E0, then HREADYOUT low for 3 cycles, then high in the 4th cycle with HRDATA valid (3 AHB wait states).
- Back-to-back transfers: the next address phase is accepted in the same cycle the previous one completes (HREADYOUT=1). There are no idle APB cycles beyond the mandatory LATCH.
- PADDR, PWRITE, PWDATA and PSTRB are held stable from SETUP through the end of ACCESS. PSEL is never asserted outside LATCH→ACCESS.
- HSEL=0 or HREADY=0 at an IDLE edge: no accept. The bridge keeps HREADYOUT=1, HRESP=0.

Test Plan:
- Reset mid-ACCESS (HRESETn low asynchronously between edges) -> PSEL, PENABLE and HRESP are 0 and HREADYOUT=1 before the next edge. After release, the next NONSEQ is serviced normally.
- Single NONSEQ word write, HADDR=0x0000_1234, HWDATA=0xDEADBEEF, PREADY=1 -> one APB transfer with PADDR=0x1234, PWDATA=0xDEADBEEF, PSTRB=4'hF. HREADYOUT low for exactly 3 cycles. HRESP=0.
- Byte read at HADDR=0x0000_0013, PREADY low for 2 ACCESS cycles, PRDATA=0x11223344 -> PSTRB=0. HREADYOUT low for 5 cycles. HRDATA=0x11223344 when HREADYOUT rises.
- Halfword write at HADDR=0x2 -> PSTRB=4'b1100. PSLVERR=1 with PREADY -> ERR1 (HRESP=1, HREADYOUT=0) then ERR2 (HRESP=1, HREADYOUT=1), then OKAY.
- INCR4 burst (NONSEQ followed by 3 SEQ, with one BUSY between beats 2 and 3), addresses 0x100 to 0x10C -> exactly 4 APB transfers in order. The BUSY gets an OKAY and triggers no APB cycle.
- HSIZE=3 NONSEQ -> two-cycle ERROR response, PSEL stays 0. HSEL=0 NONSEQ -> HREADYOUT stays 1, no APB activity.
